// File: rtl/asphalt_pio_pkg.sv
// Shared constants and helpers for the asphalt input PIO family.
package asphalt_pio_pkg;

  // Avalon-MM word addresses of the register map.
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge selection encodings for the EDGE_TYPE parameter.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Arming state after reset: captures are suppressed until ST_ARMED.
  typedef enum logic {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } arm_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/asphalt_pio_edge_in_if.sv
// Avalon-MM slave port of the edge-capturing input PIO.
//
// Bus semantics: there is no waitrequest, so every cycle is accepted.
// A write is a single-cycle strobe qualified by `write`; address and
// writedata are only meaningful while write is high. Reads need no
// strobe: readdata is registered every cycle from the current address and
// is valid one cycle after the address is presented. irq is a registered
// level, high while any unmasked edge capture is pending.
interface asphalt_pio_edge_in_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output write,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/asphalt_pio_bit_filter.sv
// One input bit: synchroniser chain followed by an optional glitch filter.
// stable_o only changes once the synchronised level has differed from it
// for FILTER_CYCLES consecutive samples; FILTER_CYCLES=0 bypasses it.
module asphalt_pio_bit_filter
  import asphalt_pio_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arm_i,
  input  logic pin_i,
  output logic synced_o,
  output logic stable_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Synchroniser shift chain; the pin enters at bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign synced_o = sync_q[SYNC_STAGES-1];

  if (FILTER_CYCLES > 0) begin : g_filter
    localparam int CNT_W = (clog2(FILTER_CYCLES + 1) > 0) ? clog2(FILTER_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             stable_q;
    logic             stable_d;

    // Next-state for the stability counter and the accepted level.
    // While disarmed the level tracks the synchroniser directly.
    always_comb begin
      cnt_inc  = cnt_q + CNT_W'(1);
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (!arm_i) begin
        stable_d = synced_o;
        cnt_d    = '0;
      end else if (synced_o == stable_q) begin
        cnt_d = '0;
      end else if (cnt_inc == CNT_W'(FILTER_CYCLES)) begin
        stable_d = synced_o;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable_o = stable_q;
  end else begin : g_bypass
    logic unused_arm;
    assign unused_arm = arm_i;
    assign stable_o   = synced_o;
  end

endmodule

// File: rtl/asphalt_pio_edge_in.sv
// Avalon-MM input PIO with per-bit glitch filtering, edge capture and a
// masked level interrupt. Captures are suppressed for SYNC_STAGES+1 cycles
// after reset so that pins already high through reset do not fire.
module asphalt_pio_edge_in
  import asphalt_pio_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int EDGE_TYPE     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_port,
  asphalt_pio_edge_in_if.slave  bus,
  output arm_state_e            dbg_state_o
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = (clog2(ARM_CYCLES + 1) > 0) ? clog2(ARM_CYCLES + 1) : 1;

  arm_state_e       state_q;
  logic [ARM_W-1:0] arm_cnt_q;
  logic             armed;

  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] capture_q;
  logic [WIDTH-1:0] capture_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic             irq_q;
  logic             irq_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr_mask;
  logic             wr_edge;

  // Arming FSM: count out the synchroniser fill time after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_DISARMED;
      arm_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
            state_q   <= ST_ARMED;
            arm_cnt_q <= '0;
          end else begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
          end
        end
        ST_ARMED: begin
          state_q <= ST_ARMED;
        end
        default: begin
          state_q   <= ST_DISARMED;
          arm_cnt_q <= '0;
        end
      endcase
    end
  end

  assign armed       = (state_q == ST_ARMED);
  assign dbg_state_o = state_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    asphalt_pio_bit_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .arm_i    (armed),
      .pin_i    (in_port[i]),
      .synced_o (synced[i]),
      .stable_o (stable[i])
    );
  end

  // Delayed copy of the accepted level; preloaded while disarmed so the
  // first armed cycle sees no difference.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_dly_q <= '0;
    end else if (!armed) begin
      stable_dly_q <= synced;
    end else begin
      stable_dly_q <= stable;
    end
  end

  // Edge selection against the delayed level.
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_hit = ~stable & stable_dly_q;
      EDGE_ANY:     edge_hit = stable ^ stable_dly_q;
      default:      edge_hit = stable & ~stable_dly_q;
    endcase
  end

  assign wr_mask  = bus.write && (bus.address == ADDR_MASK);
  assign wr_edge  = bus.write && (bus.address == ADDR_EDGE);
  assign clr_bits = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

  // Register next-state: write-one-to-clear captures where a fresh edge
  // in the same cycle keeps its bit set; interrupt from masked captures.
  always_comb begin
    capture_d = (capture_q & ~clr_bits) | (armed ? edge_hit : '0);
    mask_d    = wr_mask ? bus.writedata[WIDTH-1:0] : mask_q;
    irq_d     = |(capture_q & mask_q);
  end

  // Read mux; bits above WIDTH and the reserved word read 0.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = capture_q;
      default:   readdata_d = '0;
    endcase
  end

  // Software-visible registers and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_q  <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      capture_q  <= capture_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_asphalt_pio_edge_in.sv
// Directed bench for asphalt_pio_edge_in: three instances share clock,
// reset and pins, one per EDGE_TYPE (rising, falling, any).
module tb_asphalt_pio_edge_in;
  import asphalt_pio_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] in_port;
  arm_state_e dbg_r;
  arm_state_e dbg_f;
  arm_state_e dbg_a;

  int n_checks;
  int n_err;

  asphalt_pio_edge_in_if bus_r ();
  asphalt_pio_edge_in_if bus_f ();
  asphalt_pio_edge_in_if bus_a ();

  asphalt_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus_r), .dbg_state_o(dbg_r)
  );
  asphalt_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .EDGE_TYPE(1)) dut_f (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus_f), .dbg_state_o(dbg_f)
  );
  asphalt_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .EDGE_TYPE(2)) dut_a (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(bus_a), .dbg_state_o(dbg_a)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_drive(input int sel, input logic [1:0] a, input logic w, input logic [31:0] d);
    case (sel)
      0: begin bus_r.address = a; bus_r.write = w; bus_r.writedata = d; end
      1: begin bus_f.address = a; bus_f.write = w; bus_f.writedata = d; end
      default: begin bus_a.address = a; bus_a.write = w; bus_a.writedata = d; end
    endcase
  endtask

  // One-cycle write; address stays on the written register afterwards.
  task automatic write_reg(input int sel, input logic [1:0] a, input logic [31:0] d);
    bus_drive(sel, a, 1'b1, d);
    tick();
    bus_drive(sel, a, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rd(input int sel);
    case (sel)
      0: return bus_r.readdata;
      1: return bus_f.readdata;
      default: return bus_a.readdata;
    endcase
  endfunction

  function automatic logic [31:0] irq_of(input int sel);
    case (sel)
      0: return {31'h0, bus_r.irq};
      1: return {31'h0, bus_f.irq};
      default: return {31'h0, bus_a.irq};
    endcase
  endfunction

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset    = 1'b1;
    in_port  = 8'hFF;
    for (int s = 0; s < 3; s++) bus_drive(s, ADDR_DATA, 1'b0, 32'h0);

    // Reset with pins held high
    repeat (3) tick();
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_readdata_%0d", s), rd(s), 32'h0);
      check($sformatf("reset_irq_%0d", s), irq_of(s), 32'h0);
    end
    check("reset_state", 32'(dbg_r), 32'(ST_DISARMED));

    reset = 1'b0;
    repeat (2) tick();
    check("still_disarmed", 32'(dbg_r), 32'(ST_DISARMED));
    tick();
    check("armed", 32'(dbg_r), 32'(ST_ARMED));
    repeat (4) tick();
    check("data_ff_r", rd(0), 32'h0000_00FF);
    check("data_ff_f", rd(1), 32'h0000_00FF);

    for (int s = 0; s < 3; s++) bus_drive(s, ADDR_EDGE, 1'b0, 32'h0);
    tick();
    for (int s = 0; s < 3; s++) begin
      check($sformatf("no_spurious_edge_%0d", s), rd(s), 32'h0);
      check($sformatf("no_spurious_irq_%0d", s), irq_of(s), 32'h0);
    end

    // All pins fall: only falling/any instances capture
    in_port = 8'h00;
    repeat (10) tick();
    check("all_fall_r", rd(0), 32'h0);
    check("all_fall_f", rd(1), 32'hFF);
    check("all_fall_a", rd(2), 32'hFF);

    for (int s = 0; s < 3; s++) bus_drive(s, ADDR_EDGE, 1'b1, 32'hFF);
    tick();
    for (int s = 0; s < 3; s++) bus_drive(s, ADDR_EDGE, 1'b0, 32'h0);
    tick();
    for (int s = 0; s < 3; s++) check($sformatf("clear_all_%0d", s), rd(s), 32'h0);

    // Rising edge on bit 0 with mask 0x01: exact latency
    write_reg(0, ADDR_MASK, 32'h01);
    bus_drive(0, ADDR_DATA, 1'b0, 32'h0);
    tick();
    in_port = 8'h01;
    repeat (6) tick();
    check("data_before_accept", rd(0), 32'h00);
    tick();
    check("data_after_accept", rd(0), 32'h01);
    check("irq_not_yet", irq_of(0), 32'h0);
    tick();
    check("irq_at_8", irq_of(0), 32'h1);

    // 3-cycle glitch on bit 3 is rejected
    in_port = 8'h09;
    repeat (3) tick();
    in_port = 8'h01;
    repeat (10) tick();
    check("glitch_data", rd(0), 32'h01);
    bus_drive(0, ADDR_EDGE, 1'b0, 32'h0);
    tick();
    check("glitch_capture_r", rd(0), 32'h01);
    check("glitch_capture_a", rd(2), 32'h01);
    check("glitch_irq", irq_of(0), 32'h1);

    // 4-cycle pulse on bit 2 is just long enough to pass
    in_port = 8'h05;
    repeat (4) tick();
    in_port = 8'h01;
    repeat (14) tick();
    check("pulse4_capture_r", rd(0), 32'h05);
    check("pulse4_capture_f", rd(1), 32'h04);
    check("pulse4_capture_a", rd(2), 32'h05);

    // Write-one-to-clear bit 0 only
    write_reg(0, ADDR_EDGE, 32'h01);
    tick();
    check("rw1c_capture", rd(0), 32'h04);
    check("rw1c_irq_drops", irq_of(0), 32'h0);

    // New edge on bit 0 in the same cycle as its clear: set wins
    in_port = 8'h00;
    repeat (10) tick();
    in_port = 8'h01;
    repeat (6) tick();
    bus_drive(0, ADDR_EDGE, 1'b1, 32'h01);
    tick();
    bus_drive(0, ADDR_EDGE, 1'b0, 32'h0);
    tick();
    check("set_wins", rd(0), 32'h05);
    check("set_wins_irq", irq_of(0), 32'h1);

    // Mask control on the falling instance (captures 0x05 pending)
    check("masked_pending", rd(1), 32'h05);
    check("masked_irq", irq_of(1), 32'h0);
    write_reg(1, ADDR_MASK, 32'hFF);
    check("mask_irq_lag", irq_of(1), 32'h0);
    tick();
    check("mask_irq_on", irq_of(1), 32'h1);
    check("mask_readback", rd(1), 32'hFF);
    write_reg(1, ADDR_MASK, 32'h00);
    tick();
    check("mask_clear_irq", irq_of(1), 32'h0);

    // Bit 5 rise then fall on falling/any instances
    write_reg(1, ADDR_EDGE, 32'hFF);
    write_reg(2, ADDR_EDGE, 32'hFF);
    in_port = 8'h21;
    repeat (10) tick();
    check("fall_ignores_rise", rd(1), 32'h00);
    check("any_rise", rd(2), 32'h20);
    write_reg(2, ADDR_EDGE, 32'hFF);
    in_port = 8'h01;
    repeat (10) tick();
    check("fall_capture", rd(1), 32'h20);
    check("any_fall", rd(2), 32'h20);

    // Reset in the middle of a filter window
    in_port = 8'h81;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      check($sformatf("midreset_readdata_%0d", s), rd(s), 32'h0);
      check($sformatf("midreset_irq_%0d", s), irq_of(s), 32'h0);
    end
    check("midreset_state", 32'(dbg_a), 32'(ST_DISARMED));
    reset = 1'b0;
    repeat (10) tick();
    check("rearm_capture_r", rd(0), 32'h0);
    check("rearm_capture_a", rd(2), 32'h0);
    check("rearm_irq", irq_of(0), 32'h0);
    bus_drive(0, ADDR_DATA, 1'b0, 32'h0);
    tick();
    check("rearm_data", rd(0), 32'h81);
    bus_drive(0, ADDR_MASK, 1'b0, 32'h0);
    tick();
    check("rearm_mask", rd(0), 32'h0);
    bus_drive(0, ADDR_RSVD, 1'b0, 32'h0);
    tick();
    check("reserved_reads_0", rd(0), 32'h0);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/asphalt_pio_edge_in.md
# asphalt_pio_edge_in

Parametrised Avalon-MM input PIO: samples a WIDTH-bit asynchronous input bus through a synchroniser and an optional per-bit glitch filter. It exposes the level, a per-bit edge-capture register and an interrupt mask, and drives a level interrupt to the system interconnect. It sits on the Avalon-MM peripheral bus beside the existing single-bit input PIOs (USB GPX, keys, switches) and replaces them where edge detection or interrupts are needed.

## Interface
- WIDTH, 8: number of input bits, 1..32
- SYNC_STAGES, 2: synchroniser depth, ≥2
- FILTER_CYCLES, 4: cycles a new level must be stable before acceptance; 0 = filter bypassed
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- address  in  2  word address
- write  in  1  write strobe, single cycle
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous input pins
- readdata  out  32  registered read data
- irq  out  1  level interrupt, registered

## Operation
- Register map (bits above WIDTH read 0, writes ignored):
  - 0 DATA (RO): filtered level
  - 1 reserved: reads 0
  - 2 IRQ_MASK (RW)
  - 3 EDGE_CAPTURE (RW1C)
- Pipeline per bit: SYNC_STAGES flop chain → filter → `stable` → edge detect against `stable_d` (stable delayed 1 cycle).
- Filter (FILTER_CYCLES>0):
  - Per-bit counter, width clog2(FILTER_CYCLES+1).
  - While synced≠stable, the counter increments.
  - When synced returns to equal stable, the counter clears to 0.
  - When the counter reaches FILTER_CYCLES: stable ← synced and the counter clears.
  - A pulse shorter than FILTER_CYCLES never reaches `stable`.
- Filter bypass (FILTER_CYCLES=0): stable = last synchroniser stage.
- Edge capture:
  - edge_capture[i] sets on the selected edge of stable[i].
  - Write to address 3 clears each bit where writedata[i]=1.
  - Set and clear in the same cycle: set wins.
- irq ← |(edge_capture & irq_mask), registered.
- Arming after reset:
  - A counter holds the block disarmed for SYNC_STAGES+1 cycles after reset deasserts.
  - While disarmed, stable and stable_d load the synced value directly and no edge is captured.
  - Consequence: a pin held high through reset produces no spurious edge.

## Timing
- Reset values: readdata=0, irq=0, irq_mask=0, edge_capture=0, sync chain=0, filter counters=0, stable=0.
- Reset mid-operation clears all state on the next clk edge, including pending captures, and re-enters the disarmed period.
- in_port change → stable: SYNC_STAGES+FILTER_CYCLES cycles. Pin must be held stable for FILTER_CYCLES consecutive synced samples.
- stable change → edge_capture set: +1 cycle. edge_capture → irq: +1 cycle.
- Read latency:
  - readdata is registered every cycle from the address mux, with no read strobe.
  - readdata is valid 1 cycle after the address is presented.
- Write effect is visible in readdata 2 cycles after the write cycle and in irq 1 cycle after the register updates.
- Mask write takes effect on irq 1 cycle after the mask register updates; clearing the mask drops irq even while captures are pending.

## Structure
- Shared package `asphalt_pio_pkg`:
  - Address constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings
  - clog2 helper
- Sub-module `asphalt_pio_bit_filter`: one bit holding the sync chain, filter counter and stable output, instantiated WIDTH times via generate. Edge logic, registers and the bus mux stay in the top.

## Test plan
- Reset release with in_port=8'hFF held high → no edge captured, irq=0; DATA reads 8'hFF once armed.
- Defaults; in_port[0] 0→1 held; mask=8'h01 → DATA bit0=1 at 6 cycles; edge_capture=8'h01 at 7; irq=1 at 8.
- 3-cycle glitch on in_port[3] with FILTER_CYCLES=4 → DATA, edge_capture and irq unchanged.
- Capture pending on bits 0 and 2; write 8'h01 to address 3 → capture=8'h04. In the same cycle, a new edge on bit 0 with write 8'h01 → bit 0 stays 1.
- EDGE_TYPE=1: in_port 1→0 on bit 5 captures 8'h20, rising edge captures nothing. EDGE_TYPE=2: both edges capture.
- Pending capture with mask=0 → irq=0. Write mask=8'hFF → irq=1. Assert reset mid-pulse → all outputs 0 the next cycle.
